// File: rtl/lfsr10_checker.sv
// lfsr10_checker: self-synchronising x^10+x^7+1 PRBS checker with error counting and loss-of-lock detection
module lfsr10_checker #(
  parameter int LOCK_CONFIRM = 16,
  parameter int LOSS_WINDOW  = 64,
  parameter int LOSS_THRESH  = 8,
  parameter int ERR_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_en,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count
);
  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;
  localparam logic [7:0]  LC = 8'(LOCK_CONFIRM);
  localparam logic [15:0] LW = 16'(LOSS_WINDOW);
  localparam logic [15:0] LT = 16'(LOSS_THRESH);
  state_t state, state_n;
  logic [9:0] h, h_n;
  logic [3:0] fill_cnt, fill_n;
  logic [7:0] match_cnt, match_n;
  logic [15:0] win_bits, win_bits_n, win_errs, win_errs_n;
  logic p, miss, cmp;
  assign p = h[9] ^ h[6];
  assign miss = data_in ^ p;
  assign cmp = data_en && state == LOCKED;
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    h_n = h;
    fill_n = fill_cnt;
    match_n = match_cnt;
    win_bits_n = win_bits;
    win_errs_n = win_errs;
    if (data_en) begin
      case (state)
        FILL: begin
          h_n = {h[8:0], data_in};
          fill_n = fill_cnt == 4'd9 ? 4'd0 : fill_cnt + 4'd1;
          match_n = 8'd0;
          state_n = fill_cnt == 4'd9 ? VERIFY : FILL;
        end
        VERIFY: begin
          h_n = {h[8:0], data_in};
          match_n = match_cnt + 8'd1;
          fill_n = 4'd0;
          state_n = (miss || h == 10'd0) ? FILL : match_n == LC ? LOCKED : VERIFY;
        end
        default: begin
          h_n = {h[8:0], p};
          win_bits_n = win_bits + 16'd1;
          win_errs_n = win_errs + {15'd0, miss};
          if (win_errs_n == LT) begin
            state_n = FILL;
            fill_n = 4'd0;
            win_bits_n = 16'd0;
            win_errs_n = 16'd0;
          end else if (win_bits_n == LW) begin
            win_bits_n = 16'd0;
            win_errs_n = 16'd0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      h <= '0;
      fill_cnt <= '0;
      match_cnt <= '0;
      win_bits <= '0;
      win_errs <= '0;
      bit_err <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state <= state_n;
      h <= h_n;
      fill_cnt <= fill_n;
      match_cnt <= match_n;
      win_bits <= win_bits_n;
      win_errs <= win_errs_n;
      bit_err <= cmp && miss;
      err_count <= clear_cnt ? '0 : err_count + ERR_W'(cmp && miss && !(&err_count));
      bit_count <= clear_cnt ? '0 : bit_count + 32'(cmp && !(&bit_count));
    end
  end
endmodule

// File: tb/tb_lfsr10_checker.sv
// tb_lfsr10_checker: directed scoreboard bench for lfsr10_checker (default build plus ERR_W=4 build)
module tb_lfsr10_checker;
  localparam int LK = 0, BE = 1, EC = 2, BC = 3, E4 = 4, LK4 = 5;
  typedef struct {
    int cyc;
    int kind;
    longint val;
    int tag;
  } chk_t;
  logic clock, reset, data_in, data_en, clear_cnt;
  logic locked, bit_err, locked4, bit_err4;
  logic [15:0] err_count;
  logic [3:0] err_count4;
  logic [31:0] bit_count, bit_count4;
  logic [9:0] g;
  logic zero_mode;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  chk_t q[$];
  chk_t it;
  lfsr10_checker dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_en(data_en), .clear_cnt(clear_cnt),
    .locked(locked), .bit_err(bit_err), .err_count(err_count), .bit_count(bit_count)
  );
  lfsr10_checker #(.ERR_W(4)) dut4 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_en(data_en), .clear_cnt(clear_cnt),
    .locked(locked4), .bit_err(bit_err4), .err_count(err_count4), .bit_count(bit_count4)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic longint actual(input int kind);
    case (kind)
      LK: return longint'(locked);
      BE: return longint'(bit_err);
      EC: return longint'(err_count);
      BC: return longint'(bit_count);
      E4: return longint'(err_count4);
      default: return longint'(locked4);
    endcase
  endfunction
  function automatic string kname(input int kind);
    case (kind)
      LK: return "locked";
      BE: return "bit_err";
      EC: return "err_count";
      BC: return "bit_count";
      E4: return "err_count4";
      default: return "locked4";
    endcase
  endfunction
  always @(negedge clock) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      tests++;
      if (it.cyc != cyc) begin
        fails++;
        $display("FAIL step%0d %s: check missed at cycle %0d, wanted cycle %0d", it.tag, kname(it.kind), cyc, it.cyc);
      end else if (actual(it.kind) != it.val) begin
        fails++;
        $display("FAIL step%0d %s: got %0d, expected %0d (cycle %0d)", it.tag, kname(it.kind), actual(it.kind), it.val, cyc);
      end
    end
  end
  task automatic step(input logic en, input logic flip, input logic clr = 1'b0, input logic rst = 1'b0);
    logic nb;
    @(negedge clock);
    reset = rst;
    clear_cnt = clr;
    data_en = en;
    if (en) begin
      nb = g[9] ^ g[6];
      g = {g[8:0], nb};
      data_in = zero_mode ? 1'b0 : nb ^ flip;
    end else begin
      data_in = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic exp(input int kind, input longint val, input int tag);
    q.push_back('{cyc + 1, kind, val, tag});
  endtask
  initial begin
    g = 10'h001;
    zero_mode = 1'b0;
    reset = 1'b1;
    data_en = 1'b0;
    data_in = 1'b0;
    clear_cnt = 1'b0;
    repeat (3) step(0, 0, 0, 1);
    exp(LK, 0, 1); exp(BE, 0, 1); exp(EC, 0, 1); exp(BC, 0, 1);
    repeat (25) step(1, 0);
    exp(LK, 0, 2);
    step(1, 0);
    exp(LK, 1, 2); exp(LK4, 1, 2);
    repeat (2000) step(1, 0);
    exp(EC, 0, 2); exp(BC, 2000, 2); exp(E4, 0, 2); exp(BE, 0, 2);
    step(1, 1);
    exp(BE, 1, 3); exp(EC, 1, 3); exp(BC, 2001, 3);
    step(1, 0);
    exp(BE, 0, 3); exp(LK, 1, 3);
    repeat (20) step(1, 0);
    exp(EC, 1, 3); exp(LK, 1, 3);
    for (int i = 2; i <= 20; i++) begin
      step(1, 1);
      exp(EC, i, 4);
      if (i == 14) exp(E4, 14, 4);
      repeat (15) step(1, 0);
    end
    exp(E4, 15, 4); exp(LK, 1, 4); exp(LK4, 1, 4); exp(BC, 2326, 4);
    step(1, 1, 1);
    exp(EC, 0, 5); exp(BC, 0, 5); exp(BE, 1, 5); exp(E4, 0, 5);
    step(1, 0);
    exp(BC, 1, 5); exp(EC, 0, 5);
    repeat (104) step(1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1);
      exp(LK, longint'(i < 8), 6);
    end
    exp(EC, 8, 6); exp(BC, 113, 6); exp(BE, 1, 6);
    repeat (25) step(1, 0);
    exp(LK, 0, 6);
    step(1, 0);
    exp(LK, 1, 6); exp(EC, 8, 6); exp(BC, 113, 6);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int n = 1; n <= 26; n++) begin
      step(1, 0);
      if (n == 25) exp(LK, 0, 7);
      if (n == 26) exp(LK, 1, 7);
      step(0, 0);
      step(0, 0);
    end
    exp(LK, 1, 7); exp(BC, 0, 7);
    step(1, 1);
    exp(BE, 1, 7); exp(EC, 1, 7); exp(BC, 1, 7);
    step(0, 0);
    exp(BE, 0, 7); exp(EC, 1, 7);
    step(1, 1, 0, 1);
    exp(LK, 0, 8); exp(BE, 0, 8); exp(EC, 0, 8); exp(BC, 0, 8); exp(E4, 0, 8);
    zero_mode = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      step(1, 0);
      if (i % 100 == 0) exp(LK, 0, 9);
    end
    exp(EC, 0, 9); exp(BC, 0, 9);
    step(0, 0);
    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d checks left unserviced, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
